// File: rtl/gcd_req_ctrl.sv
// gcd_req_ctrl: initiator side of the gcd core's operand/result interface.
// It accepts one operand pair at a time and sends it to the core as a one-cycle
// start pulse. The core's result is then offered downstream on a ready/valid channel.
// If either operand is zero, the block answers directly and the core is not used.
// If the core does not answer in time, a watchdog produces a timeout response.
// Optional macro GCD_REQ_STATS_EN adds saturating response counters
// (stat_done_o, stat_timeout_o).
module gcd_req_ctrl #(
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] req_a_i,
    input  logic [WIDTH-1:0] req_b_i,
    output logic             gcd_valid_o,
    output logic [WIDTH-1:0] gcd_a_o,
    output logic [WIDTH-1:0] gcd_b_o,
    input  logic             gcd_valid_i,
    input  logic [WIDTH-1:0] gcd_result_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [WIDTH-1:0] resp_data_o,
    output logic             resp_timeout_o,
    output logic             busy_o
`ifdef GCD_REQ_STATS_EN
    ,
    output logic [15:0]      stat_done_o,
    output logic [15:0]      stat_timeout_o
`endif
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    // Last watchdog value before expiry: WAIT has then lasted TIMEOUT_CYCLES cycles.
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             tmo_q, tmo_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             edge_q;
    logic             result_edge;

    // A result counts only on its rising edge, because the core holds valid as a level.
    assign result_edge = gcd_valid_i & ~edge_q;

    // State, operand, response and watchdog registers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            tmo_q   <= 1'b0;
            wd_q    <= '0;
            edge_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
            wd_q    <= wd_d;
            edge_q  <= gcd_valid_i;
        end
    end

    // Next-state logic and outputs for the request/wait/hold sequence
    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        b_d            = b_q;
        data_d         = data_q;
        tmo_d          = tmo_q;
        wd_d           = wd_q;
        req_ready_o    = 1'b0;
        gcd_valid_o    = 1'b0;
        gcd_a_o        = '0;
        gcd_b_o        = '0;
        resp_valid_o   = 1'b0;
        resp_data_o    = '0;
        resp_timeout_o = 1'b0;
        busy_o         = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy_o = 1'b0;
                // Do not start while the core is still driving an older or late result.
                req_ready_o = ~gcd_valid_i;
                if (req_valid_i && !gcd_valid_i) begin
                    a_d = req_a_i;
                    b_d = req_b_i;
                    if (req_a_i == '0 || req_b_i == '0) begin
                        // gcd(0,x) = x and gcd(0,0) = 0, so the core is not needed.
                        data_d  = req_a_i | req_b_i;
                        tmo_d   = 1'b0;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                gcd_valid_o = 1'b1;
                gcd_a_o     = a_q;
                gcd_b_o     = b_q;
                wd_d        = '0;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                wd_d = wd_q + 1'b1;
                // A result wins over a timeout that expires in the same cycle.
                if (result_edge) begin
                    data_d  = gcd_result_i;
                    tmo_d   = 1'b0;
                    state_d = ST_HOLD;
                end else if (wd_q == WD_MAX) begin
                    data_d  = '0;
                    tmo_d   = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                resp_valid_o   = 1'b1;
                resp_data_o    = data_q;
                resp_timeout_o = tmo_q;
                if (resp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef GCD_REQ_STATS_EN
    logic [15:0] stat_done_q, stat_done_d;
    logic [15:0] stat_timeout_q, stat_timeout_d;
    logic        resp_fire;

    assign resp_fire      = resp_valid_o & resp_ready_i;
    assign stat_done_o    = stat_done_q;
    assign stat_timeout_o = stat_timeout_q;

    // Saturating counters for accepted responses
    always_comb begin
        stat_done_d    = stat_done_q;
        stat_timeout_d = stat_timeout_q;
        if (resp_fire) begin
            if (tmo_q) begin
                if (stat_timeout_q != 16'hFFFF) stat_timeout_d = stat_timeout_q + 16'd1;
            end else begin
                if (stat_done_q != 16'hFFFF) stat_done_d = stat_done_q + 16'd1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            stat_done_q    <= '0;
            stat_timeout_q <= '0;
        end else begin
            stat_done_q    <= stat_done_d;
            stat_timeout_q <= stat_timeout_d;
        end
    end
`endif

endmodule

// File: tb/tb_gcd_req_ctrl.sv
// Testbench for gcd_req_ctrl. The bench uses directed tests and
// transaction-level scoreboards, and also makes per-cycle protocol checks.
module tb_gcd_req_ctrl;

    logic       clk_i = 1'b0;
    logic       reset_ni;
    logic       req_valid_i;
    logic       req_ready_o;
    logic [7:0] req_a_i, req_b_i;
    logic       gcd_valid_o;
    logic [7:0] gcd_a_o, gcd_b_o;
    logic       gcd_valid_i;
    logic [7:0] gcd_result_i;
    logic       resp_valid_o;
    logic       resp_ready_i;
    logic [7:0] resp_data_o;
    logic       resp_timeout_o;
    logic       busy_o;
`ifdef GCD_REQ_STATS_EN
    logic [15:0] stat_done_o, stat_timeout_o;
`endif

    gcd_req_ctrl #(.WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
        .clk_i          (clk_i),
        .reset_ni       (reset_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_a_i        (req_a_i),
        .req_b_i        (req_b_i),
        .gcd_valid_o    (gcd_valid_o),
        .gcd_a_o        (gcd_a_o),
        .gcd_b_o        (gcd_b_o),
        .gcd_valid_i    (gcd_valid_i),
        .gcd_result_i   (gcd_result_i),
        .resp_valid_o   (resp_valid_o),
        .resp_ready_i   (resp_ready_i),
        .resp_data_o    (resp_data_o),
        .resp_timeout_o (resp_timeout_o),
        .busy_o         (busy_o)
`ifdef GCD_REQ_STATS_EN
        ,
        .stat_done_o    (stat_done_o),
        .stat_timeout_o (stat_timeout_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_assert = 0;
    int n_fail   = 0;
    int n_pulses = 0;
    logic [7:0]  last_data;
    logic        last_tmo;
    logic [15:0] iss_q[$];   // expected {a,b} per core pulse
    logic [8:0]  rsp_q[$];   // expected {timeout,data} per accepted response

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Mathematical gcd (Euclid)
    function automatic logic [7:0] gcd_model(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x = a, y = b, t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Response data required for a request whose core does answer
    function automatic logic [7:0] exp_data(input logic [7:0] a, input logic [7:0] b);
        return (a == 0 || b == 0) ? (a | b) : gcd_model(a, b);
    endfunction

    // Per-cycle checker: scoreboards for core pulses and responses, plus protocol rules
    int          m_done = 0, m_tmo = 0;
    logic        stall_prev = 1'b0;
    logic [7:0]  prev_data;
    logic        prev_tmo;
    always @(negedge clk_i) begin
        if (!reset_ni) begin
            m_done = 0;
            m_tmo = 0;
            stall_prev = 1'b0;
        end else begin
`ifdef GCD_REQ_STATS_EN
            chk("stat_done", stat_done_o, m_done);
            chk("stat_timeout", stat_timeout_o, m_tmo);
`endif
            if (gcd_valid_o) begin
                n_pulses++;
                chk("issue_ready_low", req_ready_o, 0);
                if (iss_q.size() == 0) chk("unexpected_issue", 1, 0);
                else chk("issue_operands", {gcd_a_o, gcd_b_o}, iss_q.pop_front());
            end else begin
                chk("ops_zero_no_pulse", {gcd_a_o, gcd_b_o}, 0);
            end
            if (!busy_o) begin
                chk("idle_ready", req_ready_o, !gcd_valid_i);
                chk("idle_no_resp", resp_valid_o, 0);
            end
            if (resp_valid_o) begin
                chk("hold_ready_low", req_ready_o, 0);
                if (stall_prev) chk("hold_stable", {resp_timeout_o, resp_data_o}, {prev_tmo, prev_data});
                if (resp_ready_i) begin
                    if (rsp_q.size() == 0) chk("unexpected_resp", 1, 0);
                    else chk("resp_value", {resp_timeout_o, resp_data_o}, rsp_q.pop_front());
                    last_data = resp_data_o;
                    last_tmo  = resp_timeout_o;
                    if (resp_timeout_o) begin
                        if (m_tmo != 65535) m_tmo++;
                    end else begin
                        if (m_done != 65535) m_done++;
                    end
                end
            end
            stall_prev = resp_valid_o & ~resp_ready_i;
            prev_data  = resp_data_o;
            prev_tmo   = resp_timeout_o;
        end
    end

    // Present an operand pair; returns #1 after the handshake edge
    task automatic send(input logic [7:0] a, input logic [7:0] b);
        int k = 0;
        req_a_i = a;
        req_b_i = b;
        req_valid_i = 1'b1;
        @(negedge clk_i);
        while (!req_ready_o && k < 50) begin
            @(negedge clk_i);
            k++;
        end
        if (!req_ready_o) chk("send_ready_bound", 0, 1);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        req_a_i = '0;
        req_b_i = '0;
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk_i);
        while (busy_o && k < 100) begin
            @(negedge clk_i);
            k++;
        end
        if (busy_o) chk("idle_bound", 0, 1);
        @(posedge clk_i);
        #1;
    endtask

    // Request that the core answers with res after dly cycles
    task automatic do_normal(input logic [7:0] a, input logic [7:0] b, input logic [7:0] res, input int dly);
        iss_q.push_back({a, b});
        rsp_q.push_back({1'b0, exp_data(a, b)});
        send(a, b);
        repeat (dly) @(posedge clk_i);
        #1;
        gcd_valid_i = 1'b1;
        gcd_result_i = res;
        @(posedge clk_i);
        #1;
        gcd_valid_i = 1'b0;
        gcd_result_i = '0;
        wait_idle();
    endtask

    task automatic do_timeout(input logic [7:0] a, input logic [7:0] b);
        iss_q.push_back({a, b});
        rsp_q.push_back({1'b1, 8'd0});
        send(a, b);
        wait_idle();
    endtask

    task automatic apply_reset();
        reset_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
    endtask

    initial begin
        int p0;
        int wcnt;
        reset_ni = 1'b0;
        req_valid_i = 1'b0;
        req_a_i = '0;
        req_b_i = '0;
        gcd_valid_i = 1'b0;
        gcd_result_i = '0;
        resp_ready_i = 1'b1;

        // Pin the model itself
        chk("model_gcd_60_84", gcd_model(8'd60, 8'd84), 12);
        chk("model_gcd_21_14", gcd_model(8'd21, 8'd14), 7);
        chk("model_bypass_0_35", exp_data(8'd0, 8'd35), 35);

        #2;
        chk("rst_ready", req_ready_o, 1);
        chk("rst_outs", {gcd_valid_o, gcd_a_o, gcd_b_o, resp_valid_o, resp_data_o, resp_timeout_o, busy_o}, 0);
        repeat (3) @(posedge clk_i);
        #1;
        reset_ni = 1'b1;

        // Normal transaction 60/84, result 12 held for 3 cycles
        p0 = n_pulses;
        iss_q.push_back({8'd60, 8'd84});
        rsp_q.push_back({1'b0, exp_data(8'd60, 8'd84)});
        send(8'd60, 8'd84);
        @(negedge clk_i);
        chk("issue_latency", gcd_valid_o, 1);
        repeat (10) @(posedge clk_i);
        #1;
        gcd_valid_i = 1'b1;
        gcd_result_i = 8'd12;
        @(negedge clk_i);
        chk("resp_not_yet", resp_valid_o, 0);
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk("resp_latency", resp_valid_o, 1);
        chk("resp_data_12", resp_data_o, 12);
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk("t1_idle", busy_o, 0);
        chk("t1_ready_held_low", req_ready_o, 0);
        @(posedge clk_i);
        #1;
        gcd_valid_i = 1'b0;
        gcd_result_i = '0;
        @(negedge clk_i);
        chk("t1_ready_back", req_ready_o, 1);
        chk("t1_one_pulse", n_pulses - p0, 1);

        // Zero-operand bypass
        p0 = n_pulses;
        rsp_q.push_back({1'b0, exp_data(8'd0, 8'd35)});
        @(posedge clk_i);
        #1;
        send(8'd0, 8'd35);
        @(negedge clk_i);
        chk("bypass_latency", resp_valid_o, 1);
        chk("bypass_data_35", resp_data_o, 35);
        wait_idle();
        rsp_q.push_back({1'b0, exp_data(8'd0, 8'd0)});
        send(8'd0, 8'd0);
        @(negedge clk_i);
        chk("bypass_zero_valid", resp_valid_o, 1);
        chk("bypass_zero_data", resp_data_o, 0);
        wait_idle();
        chk("bypass_no_pulse", n_pulses - p0, 0);

        // Watchdog timeout 9/6 with a silent core
        iss_q.push_back({8'd9, 8'd6});
        rsp_q.push_back({1'b1, 8'd0});
        send(8'd9, 8'd6);
        @(negedge clk_i);
        chk("t3_issue", gcd_valid_o, 1);
        wcnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk_i);
            #1;
            @(negedge clk_i);
            if (resp_valid_o) break;
            wcnt++;
        end
        chk("t3_wait_cycles", wcnt, 16);
        chk("t3_timeout_flag", resp_timeout_o, 1);
        chk("t3_timeout_data", resp_data_o, 0);
        @(posedge clk_i);
        #1;
        gcd_valid_i = 1'b1;
        gcd_result_i = 8'd99;
        @(negedge clk_i);
        chk("t3_late_idle", busy_o, 0);
        chk("t3_late_ready_low", req_ready_o, 0);
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        gcd_valid_i = 1'b0;
        gcd_result_i = '0;
        @(negedge clk_i);
        chk("t3_late_ready_back", req_ready_o, 1);
        chk("t3_late_no_resp", resp_valid_o, 0);

        // Downstream stall for 5 cycles on result 3
        resp_ready_i = 1'b0;
        iss_q.push_back({8'd15, 8'd9});
        rsp_q.push_back({1'b0, exp_data(8'd15, 8'd9)});
        @(posedge clk_i);
        #1;
        send(8'd15, 8'd9);
        repeat (3) @(posedge clk_i);
        #1;
        gcd_valid_i = 1'b1;
        gcd_result_i = 8'd3;
        @(posedge clk_i);
        #1;
        gcd_valid_i = 1'b0;
        gcd_result_i = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("stall_valid", resp_valid_o, 1);
            chk("stall_data_3", resp_data_o, 3);
            chk("stall_tmo", resp_timeout_o, 0);
            chk("stall_ready_low", req_ready_o, 0);
            @(posedge clk_i);
            #1;
        end
        resp_ready_i = 1'b1;
        @(negedge clk_i);
        chk("stall_still_valid", resp_valid_o, 1);
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk("stall_return_idle", busy_o, 0);
        chk("stall_resp_drop", resp_valid_o, 0);

        // Asynchronous reset in WAIT, then 21/14
        iss_q.push_back({8'd8, 8'd12});
        @(posedge clk_i);
        #1;
        send(8'd8, 8'd12);
        repeat (3) @(posedge clk_i);
        #3;
        chk("t5_in_wait", busy_o, 1);
        reset_ni = 1'b0;
        #1;
        chk("t5_rst_ready", req_ready_o, 1);
        chk("t5_rst_outs", {gcd_valid_o, gcd_a_o, gcd_b_o, resp_valid_o, resp_data_o, resp_timeout_o, busy_o}, 0);
        repeat (2) @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
        do_normal(8'd21, 8'd14, 8'd7, 4);
        chk("t5_result_7", {last_tmo, last_data}, {1'b0, 8'd7});

        // Three normal responses plus one timeout after a fresh reset
        apply_reset();
        do_normal(8'd60, 8'd84, 8'd12, 2);
        do_normal(8'd21, 8'd14, 8'd7, 5);
        do_timeout(8'd9, 8'd6);
        do_normal(8'd15, 8'd9, 8'd3, 1);
        @(negedge clk_i);
`ifdef GCD_REQ_STATS_EN
        chk("stats_done_3", stat_done_o, 3);
        chk("stats_timeout_1", stat_timeout_o, 1);
`endif
        chk("all_resp_seen", rsp_q.size(), 0);
        chk("all_issue_seen", iss_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: actual=expired required=finished");
        $fatal(1, "time limit");
    end

endmodule
